// File: rtl/filtro_presencia_pkg.sv
// Shared types and constants for the presence filter: FSM encoding, distance
// saturation value and counter width.
package filtro_presencia_pkg;

    localparam int DIST_W_DEF = 9;
    localparam int CNT_W      = 4;
    localparam logic [DIST_W_DEF-1:0] DIST_MAX = {DIST_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        LEJOS      = 2'd0,
        CONF_CERCA = 2'd1,
        CERCA      = 2'd2,
        CONF_LEJOS = 2'd3
    } estado_t;

    function automatic logic es_presente(input estado_t e);
        return (e == CERCA) || (e == CONF_LEJOS);
    endfunction

endpackage

// File: rtl/filtro_presencia_promedio_movil.sv
// Moving average over the last 2^AVG_LOG2 samples. The ring buffer starts out
// zeroed, so the output is only flagged valid once the buffer is full.
module promedio_movil
    import filtro_presencia_pkg::*;
#(
    parameter int DIST_W   = DIST_W_DEF,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_muestra_vld,
    input  logic [DIST_W-1:0] i_muestra,
    output logic [DIST_W-1:0] o_dist_prom,
    output logic              o_prom_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = DIST_W + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] WARM_FIN = AVG_LOG2'(DEPTH - 1);

    logic [DEPTH-1:0][DIST_W-1:0] r_buf;
    logic [AVG_LOG2-1:0]          r_wptr;
    logic [AVG_LOG2-1:0]          r_warm;
    logic [SUM_W-1:0]             r_sum;
    logic                         r_prom_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf        <= '0;
            r_wptr       <= '0;
            r_warm       <= '0;
            r_sum        <= '0;
            r_prom_valid <= 1'b0;
        end else begin
            r_prom_valid <= 1'b0;
            if (i_muestra_vld) begin
                r_buf[r_wptr] <= i_muestra;
                r_wptr        <= r_wptr + AVG_LOG2'(1);
                r_sum         <= r_sum - SUM_W'(r_buf[r_wptr]) + SUM_W'(i_muestra);
                // warm-up counter parks at its last value once the buffer is full
                if (r_warm == WARM_FIN)
                    r_prom_valid <= 1'b1;
                else
                    r_warm <= r_warm + AVG_LOG2'(1);
            end
        end
    end

    assign o_dist_prom  = r_sum[SUM_W-1:AVG_LOG2];
    assign o_prom_valid = r_prom_valid;

endmodule

// File: rtl/filtro_presencia.sv
// Presence filter: moving average, hysteresis + N-sample confirmation FSM and
// echo-fault detection. FILTRO_PRESENCIA_FALLA_STICKY_EN makes the fault latch.
module filtro_presencia
    import filtro_presencia_pkg::*;
#(
    parameter int DIST_W       = DIST_W_DEF,
    parameter int AVG_LOG2     = 2,
    parameter int UMBRAL_CERCA = 30,
    parameter int UMBRAL_LEJOS = 40,
    parameter int N_CONFIRM    = 3,
    parameter int MAX_FALLAS   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_dist_valid,
    input  logic [DIST_W-1:0] i_dist_cm,
    input  logic              i_dist_timeout,
    output logic [DIST_W-1:0] o_dist_prom,
    output logic              o_prom_valid,
    output logic              o_presencia,
    output logic              o_evt_llega,
    output logic              o_evt_se_va,
    output logic              o_sensor_falla
);

    localparam logic [DIST_W-1:0] W_MAX    = {DIST_W{1'b1}};
    localparam logic [DIST_W-1:0] W_CERCA  = DIST_W'(UMBRAL_CERCA);
    localparam logic [DIST_W-1:0] W_LEJOS  = DIST_W'(UMBRAL_LEJOS);
    localparam logic [CNT_W-1:0]  N_CONF_C = CNT_W'(N_CONFIRM);
    localparam logic [CNT_W-1:0]  MAX_F_C  = CNT_W'(MAX_FALLAS);

    logic              w_muestra_vld;
    logic [DIST_W-1:0] w_muestra;
    logic [DIST_W-1:0] w_dist_prom;
    logic              w_prom_valid;

    // a timeout overrides any distance presented in the same cycle
    assign w_muestra_vld = i_dist_valid | i_dist_timeout;
    assign w_muestra     = i_dist_timeout ? W_MAX : i_dist_cm;

    promedio_movil #(
        .DIST_W   (DIST_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_promedio (
        .clk          (clk),
        .reset        (reset),
        .i_muestra_vld(w_muestra_vld),
        .i_muestra    (w_muestra),
        .o_dist_prom  (w_dist_prom),
        .o_prom_valid (w_prom_valid)
    );

    estado_t          r_estado, w_estado_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [CNT_W-1:0] r_fallas, w_fallas_nxt;
    logic             r_falla, w_falla_nxt;
    logic             r_presencia, r_evt_llega, r_evt_se_va;
    logic             w_cerca, w_lejos, w_pres_nxt;

    always_comb begin
        w_fallas_nxt = r_fallas;
        if (i_dist_timeout) begin
            if (r_fallas != MAX_F_C)
                w_fallas_nxt = r_fallas + CNT_W'(1);
        end else if (i_dist_valid) begin
            w_fallas_nxt = '0;
        end
    end

`ifdef FILTRO_PRESENCIA_FALLA_STICKY_EN
    assign w_falla_nxt = r_falla | (w_fallas_nxt == MAX_F_C);
`else
    assign w_falla_nxt = (w_fallas_nxt == MAX_F_C);
`endif

    assign w_cerca   = (w_dist_prom <= W_CERCA);
    assign w_lejos   = (w_dist_prom >= W_LEJOS);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_estado_nxt = r_estado;
        w_cnt_nxt    = r_cnt;
        if (w_prom_valid) begin
            case (r_estado)
                LEJOS: if (w_cerca) begin
                    w_estado_nxt = (N_CONF_C == CNT_W'(1)) ? CERCA : CONF_CERCA;
                    w_cnt_nxt    = (N_CONF_C == CNT_W'(1)) ? '0 : CNT_W'(1);
                end
                CONF_CERCA: if (!w_cerca) begin
                    w_estado_nxt = LEJOS;
                    w_cnt_nxt    = '0;
                end else if (w_cnt_inc >= N_CONF_C) begin
                    w_estado_nxt = CERCA;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt    = w_cnt_inc;
                end
                CERCA: if (w_lejos) begin
                    w_estado_nxt = (N_CONF_C == CNT_W'(1)) ? LEJOS : CONF_LEJOS;
                    w_cnt_nxt    = (N_CONF_C == CNT_W'(1)) ? '0 : CNT_W'(1);
                end
                CONF_LEJOS: if (!w_lejos) begin
                    w_estado_nxt = CERCA;
                    w_cnt_nxt    = '0;
                end else if (w_cnt_inc >= N_CONF_C) begin
                    w_estado_nxt = LEJOS;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt    = w_cnt_inc;
                end
                default: begin
                    w_estado_nxt = LEJOS;
                    w_cnt_nxt    = '0;
                end
            endcase
        end
        // fault pins the FSM to LEJOS from the cycle it is raised until it clears
        if (w_falla_nxt || r_falla) begin
            w_estado_nxt = LEJOS;
            w_cnt_nxt    = '0;
        end
    end

    assign w_pres_nxt = es_presente(w_estado_nxt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado    <= LEJOS;
            r_cnt       <= '0;
            r_fallas    <= '0;
            r_falla     <= 1'b0;
            r_presencia <= 1'b0;
            r_evt_llega <= 1'b0;
            r_evt_se_va <= 1'b0;
        end else begin
            r_estado    <= w_estado_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fallas    <= w_fallas_nxt;
            r_falla     <= w_falla_nxt;
            r_presencia <= w_pres_nxt;
            r_evt_llega <= w_pres_nxt & ~r_presencia;
            r_evt_se_va <= ~w_pres_nxt & r_presencia;
        end
    end

    assign o_dist_prom    = w_dist_prom;
    assign o_prom_valid   = w_prom_valid;
    assign o_presencia    = r_presencia;
    assign o_evt_llega    = r_evt_llega;
    assign o_evt_se_va    = r_evt_se_va;
    assign o_sensor_falla = r_falla;

endmodule

// File: tb/tb_filtro_presencia.sv
// Directed bench for filtro_presencia with default parameters; expectations
// track FILTRO_PRESENCIA_FALLA_STICKY_EN.
module tb_filtro_presencia;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dist_valid = 1'b0;
    logic [8:0] dist_cm = '0;
    logic       dist_timeout = 1'b0;
    logic [8:0] dist_prom;
    logic       prom_valid, presencia, evt_llega, evt_se_va, sensor_falla;

    int n_total = 0;
    int n_bad   = 0;

    logic [8:0] last_prom;
    logic       last_pv, last_falla;

    filtro_presencia dut (
        .clk           (clk),
        .reset         (reset),
        .i_dist_valid  (dist_valid),
        .i_dist_cm     (dist_cm),
        .i_dist_timeout(dist_timeout),
        .o_dist_prom   (dist_prom),
        .o_prom_valid  (prom_valid),
        .o_presencia   (presencia),
        .o_evt_llega   (evt_llega),
        .o_evt_se_va   (evt_se_va),
        .o_sensor_falla(sensor_falla)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // one-cycle strobe; prom results are captured the cycle after, FSM outputs are
    // observable on return (two cycles after the strobe)
    task automatic muestra(input logic v, input logic t, input logic [8:0] cm);
        dist_valid   = v;
        dist_timeout = t;
        dist_cm      = cm;
        @(negedge clk);
        dist_valid   = 1'b0;
        dist_timeout = 1'b0;
        last_pv      = prom_valid;
        last_prom    = dist_prom;
        last_falla   = sensor_falla;
        @(negedge clk);
    endtask

    logic [8:0] exp_avg2 [6] = '{9'd80, 9'd60, 9'd40, 9'd20, 9'd20, 9'd20};

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // 1: reset state and warm-up
        do_reset();
        @(negedge clk);
        chk("rst_prom", dist_prom, 0);
        chk("rst_pv", prom_valid, 0);
        chk("rst_pres", presencia, 0);
        chk("rst_llega", evt_llega, 0);
        chk("rst_seva", evt_se_va, 0);
        chk("rst_falla", sensor_falla, 0);
        for (int i = 0; i < 4; i++) begin
            muestra(1'b1, 1'b0, 9'd100);
            chk("warm_pv", last_pv, (i == 3) ? 1 : 0);
        end
        chk("warm_prom", last_prom, 100);
        chk("warm_pres", presencia, 0);

        // 2: 100 -> 20 cm, three near averages confirm
        for (int i = 0; i < 6; i++) begin
            muestra(1'b1, 1'b0, 9'd20);
            chk("t2_pv", last_pv, 1);
            chk("t2_prom", last_prom, exp_avg2[i]);
            chk("t2_llega", evt_llega, (i == 5) ? 1 : 0);
            chk("t2_pres", presencia, (i == 5) ? 1 : 0);
        end
        @(negedge clk);
        chk("t2_llega_pulse", evt_llega, 0);

        // 3: averages wander between thresholds, hysteresis holds
        for (int i = 0; i < 8; i++) begin
            muestra(1'b1, 1'b0, (i % 2 == 0) ? 9'd45 : 9'd25);
            chk("t3_pres", presencia, 1);
            chk("t3_llega", evt_llega, 0);
            chk("t3_seva", evt_se_va, 0);
        end
        chk("t3_prom", last_prom, 35);

        // 4: four back-to-back timeouts raise the fault and force LEJOS
        dist_timeout = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_falla_pre", sensor_falla, 0);
        @(negedge clk);
        dist_timeout = 1'b0;
        chk("t4_falla", sensor_falla, 1);
        chk("t4_seva", evt_se_va, 1);
        chk("t4_pres", presencia, 0);
        @(negedge clk);
        chk("t4_seva_pulse", evt_se_va, 0);
        chk("t4_falla_hold", sensor_falla, 1);
        muestra(1'b1, 1'b0, 9'd20);
`ifdef FILTRO_PRESENCIA_FALLA_STICKY_EN
        chk("t4_falla_good", last_falla, 1);
`else
        chk("t4_falla_good", last_falla, 0);
`endif
        chk("t4_pres_after", presencia, 0);

        // 5: simultaneous strobes take exactly one 511 sample
        do_reset();
        muestra(1'b1, 1'b1, 9'd10);
        chk("t5_pv0", last_pv, 0);
        chk("t5_falla", last_falla, 0);
        for (int i = 0; i < 3; i++) begin
            muestra(1'b1, 1'b0, 9'd1);
            chk("t5_pv", last_pv, (i == 2) ? 1 : 0);
        end
        chk("t5_prom", last_prom, 128);

        // 6: reset mid-confirmation discards history
        do_reset();
        for (int i = 0; i < 5; i++) muestra(1'b1, 1'b0, 9'd20);
        chk("t6_pres_pre", presencia, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_prom", dist_prom, 0);
        chk("t6_pv", prom_valid, 0);
        chk("t6_pres", presencia, 0);
        chk("t6_falla", sensor_falla, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            muestra(1'b1, 1'b0, 9'd20);
            chk("t6_warm_pv", last_pv, (i == 3) ? 1 : 0);
            chk("t6_llega", evt_llega, 0);
        end
        chk("t6_prom_after", last_prom, 20);
        chk("t6_pres_after", presencia, 0);

        // 7: averages exactly at 30 (near) and 40 (far)
        do_reset();
        for (int i = 0; i < 6; i++) begin
            muestra(1'b1, 1'b0, 9'd30);
            chk("t7_llega", evt_llega, (i == 5) ? 1 : 0);
        end
        chk("t7_pres_in", presencia, 1);
        for (int i = 0; i < 6; i++) begin
            muestra(1'b1, 1'b0, 9'd40);
            chk("t7_seva", evt_se_va, (i == 5) ? 1 : 0);
            chk("t7_pres", presencia, (i == 5) ? 0 : 1);
        end
        chk("t7_prom", last_prom, 40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
